// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: register file with WB write-through, operand muxing,
// and a single-entry valid/ready pipeline register feeding the ALU.
package id_ex_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } t_alu_op;
endpackage

module id_ex_operand_stage
    import id_ex_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int NUM_REGS      = 32,
    parameter bit RF_RESET_ZERO = 1'b1,
    localparam int AW           = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_we,
    input  t_alu_op         id_alu_op,
    input  logic            id_sel_a,
    input  logic            id_sel_b,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output t_alu_op         alu_op,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_rd_we
);

    typedef struct packed {
        t_alu_op         op;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] rs2_data;
        logic [AW-1:0]   rd;
        logic            rd_we;
    } t_payload;

    logic [XLEN-1:0] rf [NUM_REGS];
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            capture;
    t_payload        pay_d, pay_q;

    function automatic logic [XLEN-1:0] rf_read(input logic [AW-1:0] idx);
        if (idx == '0)
            return '0;
        else if (wb_we && wb_rd == idx)
            return wb_data;
        else
            return rf[idx];
    endfunction

    // Entry 0 is never written, so x0 reads stay zero even without reset clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (RF_RESET_ZERO) begin
                for (int i = 0; i < NUM_REGS; i++)
                    rf[i] <= '0;
            end
        end else if (wb_we && wb_rd != '0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    assign rs1_data = rf_read(id_rs1);
    assign rs2_data = rf_read(id_rs2);

    assign id_ready = !ex_valid || ex_ready;
    assign capture  = id_valid && id_ready && !flush;

    always_comb begin
        pay_d          = pay_q;
        pay_d.op       = id_alu_op;
        pay_d.in1      = id_sel_a ? id_pc  : rs1_data;
        pay_d.in2      = id_sel_b ? id_imm : rs2_data;
        pay_d.rs2_data = rs2_data;
        pay_d.rd       = id_rd;
        pay_d.rd_we    = id_rd_we;
    end

    // Payload only moves on capture, so a stall holds operands bit-stable
    // even while WB rewrites the source registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            pay_q    <= '{op: ALU_ADD, in1: '0, in2: '0, rs2_data: '0, rd: '0, rd_we: 1'b0};
        end else begin
            if (flush)
                ex_valid <= 1'b0;
            else if (capture)
                ex_valid <= 1'b1;
            else
                ex_valid <= ex_valid && !ex_ready;
            if (capture)
                pay_q <= pay_d;
        end
    end

    assign alu_op      = pay_q.op;
    assign alu_in1     = pay_q.in1;
    assign alu_in2     = pay_q.in2;
    assign ex_rs2_data = pay_q.rs2_data;
    assign ex_rd       = pay_q.rd;
    assign ex_rd_we    = pay_q.rd_we && ex_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: RF model plus a scoreboard of
// expected ID/EX entries, compared every cycle while an entry is valid.
module tb_id_ex_operand_stage;
    import id_ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rd_we;
    t_alu_op     id_alu_op;
    logic        id_sel_a, id_sel_b;
    logic [31:0] id_pc, id_imm;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush, ex_ready, ex_valid;
    t_alu_op     alu_op;
    logic [31:0] alu_in1, alu_in2, ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(32), .NUM_REGS(32), .RF_RESET_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_alu_op(id_alu_op), .id_sel_a(id_sel_a), .id_sel_b(id_sel_b),
        .id_pc(id_pc), .id_imm(id_imm),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] in1, in2, rs2d;
        logic [4:0]  rd;
        logic        rd_we;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mrf [32];
    logic        m_valid;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_we && wb_rd == r) return wb_data;
        return mrf[r];
    endfunction

    // Check the current cycle at the falling edge, then advance the model
    // over the rising edge and return #1 after it.
    task automatic tick();
        exp_t e, n;
        logic cap;
        @(negedge clk);
        chk("id_ready", 32'(id_ready), 32'(!m_valid || ex_ready));
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        if (m_valid && sbq.size() > 0) begin
            e = sbq[0];
            chk("alu_op", 32'(alu_op), 32'(e.op));
            chk("alu_in1", alu_in1, e.in1);
            chk("alu_in2", alu_in2, e.in2);
            chk("ex_rs2_data", ex_rs2_data, e.rs2d);
            chk("ex_rd", 32'(ex_rd), 32'(e.rd));
            chk("ex_rd_we", 32'(ex_rd_we), 32'(e.rd_we));
        end else if (!m_valid) begin
            chk("ex_rd_we_idle", 32'(ex_rd_we), 32'd0);
        end
        cap    = id_valid && (!m_valid || ex_ready) && !flush;
        n.op   = id_alu_op;
        n.in1  = id_sel_a ? id_pc : mread(id_rs1);
        n.in2  = id_sel_b ? id_imm : mread(id_rs2);
        n.rs2d = mread(id_rs2);
        n.rd   = id_rd;
        n.rd_we = id_rd_we;
        if (m_valid && (ex_ready || flush) && sbq.size() > 0) void'(sbq.pop_front());
        if (rst) begin
            sbq.delete();
            m_valid = 1'b0;
            for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        end else begin
            if (wb_we && wb_rd != 5'd0) mrf[wb_rd] = wb_data;
            if (cap) sbq.push_back(n);
            m_valid = cap || (m_valid && !ex_ready && !flush);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic sa, input logic sb, input logic [31:0] pc,
                         input logic [31:0] imm, input t_alu_op op);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_we = 1'b1;
        id_sel_a = sa; id_sel_b = sb; id_pc = pc; id_imm = imm; id_alu_op = op;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_op"}, 32'(alu_op), 32'(ALU_ADD));
        chk({tag, "_in1"}, alu_in1, 32'd0);
        chk({tag, "_in2"}, alu_in2, 32'd0);
        chk({tag, "_rs2d"}, ex_rs2_data, 32'd0);
        chk({tag, "_rd"}, 32'(ex_rd), 32'd0);
        chk({tag, "_rdwe"}, 32'(ex_rd_we), 32'd0);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd_we = 1'b0;
        id_alu_op = ALU_ADD; id_sel_a = 1'b0; id_sel_b = 1'b0; id_pc = '0; id_imm = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
        m_valid = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst0");
        rst = 1'b0;

        // 1: zero operands from a freshly reset RF
        instr(5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 32'h0, 32'h0, ALU_ADD);
        tick();
        chk("t1_valid", 32'(ex_valid), 32'd1);
        chk("t1_in1", alu_in1, 32'd0);
        chk("t1_in2", alu_in2, 32'd0);

        // 2: write-through bypass, and x0 writes dropped
        instr(5'd5, 5'd0, 5'd2, 1'b0, 1'b0, 32'h0, 32'h0, ALU_SUB);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        tick();
        chk("t2_bypass", alu_in1, 32'h1234);
        instr(5'd0, 5'd5, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0, ALU_OR);
        wb_rd = 5'd0; wb_data = 32'hFFFF;
        tick();
        chk("t2_x0_same", alu_in1, 32'd0);
        wb_we = 1'b0;
        tick();
        chk("t2_x0_after", alu_in1, 32'd0);
        chk("t2_x5_stored", alu_in2, 32'h1234);

        // 3: pc / imm operand select, store data still from rs2
        instr(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFC, ALU_ADD);
        tick();
        chk("t3_in1", alu_in1, 32'h100);
        chk("t3_in2", alu_in2, 32'hFFFF_FFFC);
        chk("t3_rs2d", ex_rs2_data, 32'h1234);

        // 4: three stall cycles with WB rewriting the held sources
        ex_ready = 1'b0;
        instr(5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 32'h0, 32'h0, ALU_XOR);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hBEEF;
        tick();
        wb_rd = 5'd3; wb_data = 32'h3333;
        tick();
        wb_rd = 5'd5; wb_data = 32'h5555;
        tick();
        chk("t4_ready", 32'(id_ready), 32'd0);
        chk("t4_hold_in1", alu_in1, 32'h100);
        chk("t4_hold_rs2d", ex_rs2_data, 32'h1234);
        wb_we = 1'b0; ex_ready = 1'b1;
        tick();
        chk("t4_new_in1", alu_in1, 32'h5555);
        chk("t4_new_rd", 32'(ex_rd), 32'd7);

        // 5: flush kills held and offered entries; reset mid-stall
        ex_ready = 1'b0; flush = 1'b1;
        instr(5'd3, 5'd3, 5'd8, 1'b0, 1'b0, 32'h0, 32'h0, ALU_AND);
        tick();
        chk("t5_flush_valid", 32'(ex_valid), 32'd0);
        chk("t5_flush_rdwe", 32'(ex_rd_we), 32'd0);
        flush = 1'b0;
        tick();
        id_valid = 1'b0;
        tick();
        rst = 1'b1; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999;
        tick();
        chk_reset_vals("t5_rst");
        rst = 1'b0; wb_we = 1'b0; ex_ready = 1'b1;
        instr(5'd5, 5'd9, 5'd10, 1'b0, 1'b0, 32'h0, 32'h0, ALU_ADD);
        tick();
        chk("t5_rf_cleared", alu_in1, 32'd0);
        chk("t5_rst_wb_drop", alu_in2, 32'd0);

        // 6: back-to-back traffic with random WB activity
        for (int i = 0; i < 8; i++) begin
            instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  t_alu_op'($urandom_range(0, 9)));
            wb_we = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 31)); wb_data = $urandom;
            if (i == 3) begin
                wb_we = 1'b1; wb_rd = id_rs1;
            end
            tick();
            chk("t6_valid", 32'(ex_valid), 32'd1);
        end
        id_valid = 1'b0; wb_we = 1'b0;
        tick();
        tick();
        chk("t6_drained", 32'(ex_valid), 32'd0);
        chk("t6_sb_empty", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
